alu_issue_ctrl: RTL and testbench

Multi-cycle controller that sits in front of the 64-bit datapath ALU and drives its 4-bit opcode port.
- Accepts one LEGv8 instruction word per valid/ready handshake.
- Decodes it into ALU opcode, register addresses and B-operand immediate.
- Holds those stable while the ALU evaluates, then samples the ALU result and zero flag.
- Emits either a register writeback or a CBZ/CBNZ branch decision.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/legv8_field_decode.sv | 76 +++++++
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the LEGv8 ALU issue path: ALU opcodes, LEGv8 opcode fields, FSM states.
// The optional illegal-instruction trap is selected by ALU_ISSUE_ILLEGAL_TRAP_EN.
package alu_pkg;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_NOT  = 4'b0011;
  localparam logic [3:0] ALU_MOVA = 4'b0100;
  localparam logic [3:0] ALU_MOVB = 4'b0101;
  localparam logic [3:0] ALU_ADD  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_MOVK = 4'b1000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [8:0]  OP_MOVZ = 9'b110100101;
  localparam logic [8:0]  OP_MOVK = 9'b111100101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RETIRE = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_WB   = 2'd1,
    CLS_BR   = 2'd2
  } instr_class_e;

endpackage

// File: rtl/legv8_field_decode.sv
// Purely combinational LEGv8 field decoder: instruction word -> ALU controls, addresses,
// immediate, branch offset, class and illegal flag.
module legv8_field_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  output logic [3:0]      alu_op_o,
  output logic [4:0]      rn_addr_o,
  output logic [4:0]      rm_addr_o,
  output logic [4:0]      rd_addr_o,
  output logic            b_sel_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] br_offset_o,
  output instr_class_e    class_o,
  output logic            is_cbnz_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] imm12_zx;
  logic [XLEN-1:0] imm16_zx;

  assign imm12_zx    = {{(XLEN-12){1'b0}}, instr_i[21:10]};
  assign imm16_zx    = {{(XLEN-16){1'b0}}, instr_i[20:5]};
  // imm19 counts instruction words; the byte offset is that value times four.
  assign br_offset_o = {{(XLEN-21){instr_i[23]}}, instr_i[23:5], 2'b00};

  always_comb begin
    alu_op_o  = ALU_NOP;
    rn_addr_o = instr_i[9:5];
    rm_addr_o = instr_i[20:16];
    rd_addr_o = instr_i[4:0];
    b_sel_o   = 1'b0;
    imm_o     = '0;
    class_o   = CLS_NONE;
    is_cbnz_o = 1'b0;
    illegal_o = 1'b1;
    if (instr_i[31:21] == OP_ADD || instr_i[31:21] == OP_SUB ||
        instr_i[31:21] == OP_AND || instr_i[31:21] == OP_ORR) begin
      class_o   = CLS_WB;
      illegal_o = 1'b0;
      if (instr_i[31:21] == OP_ADD)      alu_op_o = ALU_ADD;
      else if (instr_i[31:21] == OP_SUB) alu_op_o = ALU_SUB;
      else if (instr_i[31:21] == OP_AND) alu_op_o = ALU_AND;
      else                               alu_op_o = ALU_OR;
    end else if (instr_i[31:22] == OP_ADDI || instr_i[31:22] == OP_SUBI) begin
      class_o   = CLS_WB;
      illegal_o = 1'b0;
      alu_op_o  = (instr_i[31:22] == OP_ADDI) ? ALU_ADD : ALU_SUB;
      b_sel_o   = 1'b1;
      imm_o     = imm12_zx;
    end else if (instr_i[31:23] == OP_MOVZ) begin
      class_o   = CLS_WB;
      illegal_o = 1'b0;
      alu_op_o  = ALU_MOVB;
      b_sel_o   = 1'b1;
      imm_o     = imm16_zx << {instr_i[22:21], 4'b0000};
    end else if (instr_i[31:23] == OP_MOVK && instr_i[22:21] == 2'b00) begin
      // The ALU only inserts the low halfword, so MOVK with a shift stays illegal.
      class_o   = CLS_WB;
      illegal_o = 1'b0;
      alu_op_o  = ALU_MOVK;
      rn_addr_o = instr_i[4:0];
      b_sel_o   = 1'b1;
      imm_o     = imm16_zx;
    end else if (instr_i[31:24] == OP_CBZ || instr_i[31:24] == OP_CBNZ) begin
      class_o   = CLS_BR;
      illegal_o = 1'b0;
      alu_op_o  = ALU_MOVB;
      rm_addr_o = instr_i[4:0];
      is_cbnz_o = instr_i[24];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle LEGv8 issue controller in front of the 64-bit ALU (IDLE->DECODE->EXEC->RETIRE).
// Define ALU_ISSUE_ILLEGAL_TRAP_EN to make illegal instructions trap until reset.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter logic [4:0]  ZERO_REG = 5'd31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [3:0]      alu_op,
  output logic [4:0]      rn_addr,
  output logic [4:0]      rm_addr,
  output logic            alu_b_sel,
  output logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_offset,
  output logic            done,
  output logic            illegal
);

  // Handshake: a word transfers on a rising edge where instr_valid and instr_ready are both 1;
  // instr_ready is high only in IDLE, so at most one instruction is in flight.

  state_e          state_q;
  logic [31:0]     instr_q;
  instr_class_e    class_q;
  logic            is_cbnz_q, ill_q, zero_q;
  logic [XLEN-1:0] res_q;
  logic            ready_q, b_sel_q, wb_en_q, br_taken_q, done_q, illegal_q;
  logic [3:0]      alu_op_q;
  logic [4:0]      rn_q, rm_q, wb_rd_q;
  logic [XLEN-1:0] imm_q, wb_data_q, br_offset_q;

  logic [3:0]      dec_alu_op;
  logic [4:0]      dec_rn, dec_rm, dec_rd;
  logic            dec_b_sel, dec_cbnz, dec_illegal;
  logic [XLEN-1:0] dec_imm, dec_br_offset;
  instr_class_e    dec_class;

  legv8_field_decode #(.XLEN(XLEN)) u_decode (
    .instr_i     (instr_q),
    .alu_op_o    (dec_alu_op),
    .rn_addr_o   (dec_rn),
    .rm_addr_o   (dec_rm),
    .rd_addr_o   (dec_rd),
    .b_sel_o     (dec_b_sel),
    .imm_o       (dec_imm),
    .br_offset_o (dec_br_offset),
    .class_o     (dec_class),
    .is_cbnz_o   (dec_cbnz),
    .illegal_o   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      class_q     <= CLS_NONE;
      is_cbnz_q   <= 1'b0;
      ill_q       <= 1'b0;
      zero_q      <= 1'b0;
      res_q       <= '0;
      ready_q     <= 1'b1;
      alu_op_q    <= ALU_NOP;
      rn_q        <= '0;
      rm_q        <= '0;
      b_sel_q     <= 1'b0;
      imm_q       <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      br_offset_q <= '0;
      wb_en_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      wb_en_q    <= 1'b0;
      br_taken_q <= 1'b0;
`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (instr_valid && ready_q) begin
            instr_q <= instr;
            ready_q <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_op_q    <= dec_alu_op;
          rn_q        <= dec_rn;
          rm_q        <= dec_rm;
          b_sel_q     <= dec_b_sel;
          imm_q       <= dec_imm;
          wb_rd_q     <= dec_rd;
          br_offset_q <= dec_br_offset;
          class_q     <= dec_class;
          is_cbnz_q   <= dec_cbnz;
          ill_q       <= dec_illegal;
          state_q     <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q   <= alu_result;
          zero_q  <= alu_zero;
          state_q <= ST_RETIRE;
        end
        ST_RETIRE: begin
          done_q <= 1'b1;
          case (class_q)
            CLS_WB: begin
              wb_en_q   <= (wb_rd_q != ZERO_REG);
              wb_data_q <= res_q;
            end
            CLS_BR:  br_taken_q <= is_cbnz_q ? ~zero_q : zero_q;
            default: ;
          endcase
          if (ill_q) illegal_q <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
          if (ill_q) begin
            state_q <= ST_TRAP;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
`else
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
`endif
        end
        ST_TRAP: state_q <= ST_TRAP;
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign alu_op      = alu_op_q;
  assign rn_addr     = rn_q;
  assign rm_addr     = rm_q;
  assign alu_b_sel   = b_sel_q;
  assign imm         = imm_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign br_taken    = br_taken_q;
  assign br_offset   = br_offset_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl; reference decode built from LEGv8 field arithmetic.
// Honours ALU_ISSUE_ILLEGAL_TRAP_EN for the illegal-instruction section.
module tb_alu_issue_ctrl;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [3:0]      alu_op;
  logic [4:0]      rn_addr, rm_addr, wb_rd;
  logic            alu_b_sel, alu_zero, wb_en, br_taken, done, illegal;
  logic [XLEN-1:0] imm, alu_result, wb_data, br_offset;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    int          kind;   // 0 writeback, 1 branch, 2 illegal
    logic [3:0]  op;
    int          rn;     // -1 when not meaningful
    int          rm;
    bit          bsel;
    logic [63:0] imm;
    int          rd;
    bit          cbnz;
    longint      ofs;
  } ref_t;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_op(alu_op), .rn_addr(rn_addr), .rm_addr(rm_addr), .alu_b_sel(alu_b_sel), .imm(imm),
    .alu_result(alu_result), .alu_zero(alu_zero), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_taken(br_taken), .br_offset(br_offset), .done(done), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ref_t ref_model(input logic [31:0] w);
    ref_t r;
    int unsigned u, op11, op10, op9, op8, imm16, hw, imm19;
    u = w; op11 = u >> 21; op10 = u >> 22; op9 = u >> 23; op8 = u >> 24;
    imm16 = (u >> 5) % 65536; hw = (u >> 21) % 4; imm19 = (u >> 5) % (1 << 19);
    r.kind = 2; r.op = 4'd0; r.rn = -1; r.rm = -1; r.bsel = 0; r.imm = 0;
    r.rd = u % 32; r.cbnz = 0; r.ofs = 0;
    if (op11 == 'h458 || op11 == 'h658 || op11 == 'h450 || op11 == 'h550) begin
      r.kind = 0; r.rn = (u >> 5) % 32; r.rm = (u >> 16) % 32;
      r.op = (op11 == 'h458) ? 4'd6 : (op11 == 'h658) ? 4'd7 : (op11 == 'h450) ? 4'd1 : 4'd2;
    end else if (op10 == 'h244 || op10 == 'h344) begin
      r.kind = 0; r.rn = (u >> 5) % 32; r.bsel = 1; r.imm = (u >> 10) % 4096;
      r.op = (op10 == 'h244) ? 4'd6 : 4'd7;
    end else if (op9 == 'h1A5) begin
      r.kind = 0; r.op = 4'd5; r.bsel = 1; r.imm = 64'(imm16) << (16 * hw);
    end else if (op9 == 'h1E5 && hw == 0) begin
      r.kind = 0; r.op = 4'd8; r.rn = r.rd; r.bsel = 1; r.imm = imm16;
    end else if (op8 == 'hB4 || op8 == 'hB5) begin
      r.kind = 1; r.op = 4'd5; r.rm = r.rd; r.cbnz = (op8 == 'hB5);
      r.ofs = (imm19 >= (1 << 18)) ? (longint'(imm19) - (1 << 19)) * 4 : longint'(imm19) * 4;
    end
    return r;
  endfunction

  // Present w at a negedge once ready, hold through the accept edge, return at the EXEC negedge.
  task automatic issue(input logic [31:0] w);
    int waited = 0;
    while (!instr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      n_checks++; n_fail++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    instr = w; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom;
    check("decode_done_low", done, 0);
`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("illegal_pulse_width", illegal, 0);
`endif
    @(negedge clk);
  endtask

  task automatic check_decode(input ref_t r);
    check("alu_op", alu_op, r.op);
    if (r.rn >= 0) check("rn_addr", rn_addr, r.rn);
    if (r.rm >= 0) check("rm_addr", rm_addr, r.rm);
    if (r.kind != 2) begin
      check("alu_b_sel", alu_b_sel, r.bsel);
      check("wb_rd", wb_rd, r.rd);
    end
    if (r.bsel) check("imm", imm, r.imm);
  endtask

  task automatic finish(input ref_t r, input logic [XLEN-1:0] res, input bit zero);
    bit exp_wb, exp_br;
    alu_result = res; alu_zero = zero;
    exp_wb = (r.kind == 0) && (r.rd != 31);
    exp_br = (r.kind == 1) && (r.cbnz ? !zero : zero);
    if (exp_wb) exp_q.push_back(res);
    @(negedge clk);
    check("retire_done_early", done, 0);
    check("alu_op_hold", alu_op, r.op);
    alu_result = {$urandom, $urandom}; alu_zero = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("done", done, 1);
    check("wb_en", wb_en, exp_wb);
    if (exp_wb && exp_q.size() > 0) check("wb_data", wb_data, exp_q.pop_front());
    check("br_taken", br_taken, exp_br);
    if (exp_br) check("br_offset", br_offset, 64'(r.ofs));
    check("illegal", illegal, r.kind == 2);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("instr_ready_after", instr_ready, r.kind != 2);
`else
    check("instr_ready_after", instr_ready, 1);
`endif
  endtask

  task automatic run(input logic [31:0] w, input logic [XLEN-1:0] res, input bit zero);
    ref_t r;
    r = ref_model(w);
    issue(w);
    check_decode(r);
    finish(r, res, zero);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", instr_ready, 1);
    check("reset_illegal", illegal, 0);
    check("reset_alu_op", alu_op, 0);
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_illegal);
    int unsigned k;
    logic [31:0] w;
    k = $urandom_range(0, allow_illegal ? 10 : 9);
    case (k)
      0: w = 32'h8B000000; 1: w = 32'hCB000000; 2: w = 32'h8A000000; 3: w = 32'hAA000000;
      4: w = 32'h91000000; 5: w = 32'hD1000000; 6: w = 32'hD2800000; 7: w = 32'hF2800000;
      8: w = 32'hB4000000; 9: w = 32'hB5000000; default: w = $urandom;
    endcase
    if (k <= 3)      w = w | ($urandom_range(0, 31) << 16) | ($urandom_range(0, 31) << 5) | $urandom_range(0, 31);
    else if (k <= 5) w = w | ($urandom_range(0, 4095) << 10) | ($urandom_range(0, 31) << 5) | $urandom_range(0, 31);
    else if (k <= 7) w = w | ((allow_illegal || k == 6 ? $urandom_range(0, 3) : 0) << 21)
                           | ($urandom_range(0, 65535) << 5) | $urandom_range(0, 31);
    else if (k <= 9) w = w | ($urandom_range(0, 524287) << 5) | $urandom_range(0, 31);
    return w;
  endfunction

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; alu_result = '0; alu_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_instr_ready", instr_ready, 1);
    check("rst_alu_op", alu_op, 0);
    check("rst_done", done, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_illegal", illegal, 0);
    check("rst_imm", imm, 0);
    rst = 1'b0;
    @(negedge clk);

    run(32'h8B030041, 64'd5, 1'b0);
    run(32'hD10028C5, 64'h123, 1'b0);
    run(32'hD2B7DDE7, 64'h00000000BEEF0000, 1'b0);
    check("movz_imm_literal", imm, 64'h00000000BEEF0000);
    run(32'hB4000104, 64'd0, 1'b1);
    check("cbz_offset_literal", br_offset, 64'd32);
    run(32'hB4000104, 64'd7, 1'b0);
    run(32'hB5FFFFE2, 64'd9, 1'b0);
    run(32'hF29579A3, 64'hDEAD, 1'b0);

    issue(32'h8B030041);
    alu_result = 64'd5;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_done", done, 0);
    check("abort_wb_en", wb_en, 0);
    check("abort_ready", instr_ready, 1);
    @(negedge clk);
    check("abort_done_later", done, 0);
    check("abort_wb_en_later", wb_en, 0);
    run(32'h8B03005F, 64'd77, 1'b0);

    for (int i = 0; i < 40; i++) begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      run(rand_instr(1'b0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
`else
      run(rand_instr(1'b1), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
`endif
    end

    run(32'hFFFFFFFF, 64'd1, 1'b0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    instr = 32'h8B030041; instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("trap_ready_low", instr_ready, 0);
      check("trap_illegal_sticky", illegal, 1);
      check("trap_no_done", done, 0);
    end
    instr_valid = 1'b0;
    pulse_reset();
    run(32'hF2A00001, 64'd1, 1'b0);
    pulse_reset();
    run(32'h8B030041, 64'd11, 1'b0);
`else
    run(32'h8B030041, 64'd11, 1'b0);
    run(32'hF2A00001, 64'd1, 1'b0);
    run(32'hF2800001, 64'd2, 1'b0);
    pulse_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
